// File: rtl/ps2_pkg.sv
// Shared PS/2 types, error codes and default timing for the host transmitter and receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SHIFT,
        ACK,
        WAIT_RELEASE,
        FINISH
    } ps2_state_t;

    typedef logic [1:0] ps2_err_t;

    localparam ps2_err_t PS2_OK      = 2'd0;
    localparam ps2_err_t PS2_ERR_REQ = 2'd1;
    localparam ps2_err_t PS2_ERR_PKT = 2'd2;
    localparam ps2_err_t PS2_ERR_ACK = 2'd3;

    // Defaults for an 83.333 MHz main_clk.
    localparam int PS2_INHIBIT_CYCLES     = 9000;     // ~108 us clock-low request
    localparam int PS2_FILTER_CYCLES      = 8;
    localparam int PS2_REQ_TIMEOUT_CYCLES = 1250000;  // 15 ms
    localparam int PS2_PKT_TIMEOUT_CYCLES = 166667;   // 2 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_host_transmitter_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// Latency: n/a (wiring only).
// Backpressure: tx_ready gates acceptance; a transfer happens on tx_valid && tx_ready.
// Signals: tx_valid/tx_data from requester; tx_ready, busy, done_pulse, error_code back.
interface ps2_host_transmitter_if;
    import ps2_pkg::*;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       busy;
    logic       done_pulse;
    ps2_err_t   error_code;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, busy, done_pulse, error_code
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, busy, done_pulse, error_code
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises one asynchronous PS/2 pin and debounces it with a stability counter.
// Latency: 2 sync cycles + FILTER_CYCLES cycles of stable input before level follows.
// Backpressure: none; free-running.
// Ports: main_clk, reset (sync, active-high), raw (async pin), level (filtered, resets to 1).
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic main_clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int FW = $clog2(FILTER_CYCLES) + 1;
    localparam logic [FW-1:0] LAST = FW'(FILTER_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [FW-1:0] cnt_q;

    always_ff @(posedge main_clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            level  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], raw};
            // Any cycle agreeing with the current level restarts the stability window.
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q >= LAST) begin
                level <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + FW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_transmitter.sv
// Sends one command byte host-to-device on PS/2 and checks the device acknowledge.
// Latency: INHIBIT_CYCLES of clock hold, then paced by the device clock; done_pulse ends every transfer.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is ignored.
// Ports: main_clk, reset, tx_if (slave handshake), rx_inhibit, raw pins in, open-drain pulldowns out.
module ps2_host_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES     = PS2_INHIBIT_CYCLES,
    parameter int FILTER_CYCLES      = PS2_FILTER_CYCLES,
    parameter int REQ_TIMEOUT_CYCLES = PS2_REQ_TIMEOUT_CYCLES,
    parameter int PKT_TIMEOUT_CYCLES = PS2_PKT_TIMEOUT_CYCLES
) (
    input  logic                        main_clk,
    input  logic                        reset,
    ps2_host_transmitter_if.slave       tx_if,
    output logic                        rx_inhibit,
    input  logic                        ps2_clock_in,
    input  logic                        ps2_data_in,
    output logic                        ps2_clock_pulldown,
    output logic                        ps2_data_pulldown
);

    localparam int MAX_CYC = max_int(max_int(INHIBIT_CYCLES, FILTER_CYCLES),
                                     max_int(REQ_TIMEOUT_CYCLES, PKT_TIMEOUT_CYCLES));
    localparam int CNT_W = $clog2(MAX_CYC) + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t INH_DATA = cnt_t'(INHIBIT_CYCLES - 2);
    localparam cnt_t INH_LAST = cnt_t'(INHIBIT_CYCLES - 1);
    localparam cnt_t REQ_LAST = cnt_t'(REQ_TIMEOUT_CYCLES - 1);
    localparam cnt_t PKT_LAST = cnt_t'(PKT_TIMEOUT_CYCLES - 1);

    ps2_state_t state_q, state_d;
    cnt_t       cnt_q, cnt_d, cnt_inc;
    cnt_t       pkt_q, pkt_d, pkt_inc;
    logic [3:0] edge_q, edge_d, n;
    logic [7:0] byte_q, byte_d;
    logic       parity_q, parity_d;
    logic       ack_err_q, ack_err_d;
    ps2_err_t   err_q, err_d;
    logic       clk_pd_q, clk_pd_d;
    logic       data_pd_q, data_pd_d;
    logic       clk_f, data_f, clk_f_prev, clk_fall;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .main_clk (main_clk),
        .reset    (reset),
        .raw      (ps2_clock_in),
        .level    (clk_f)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
        .main_clk (main_clk),
        .reset    (reset),
        .raw      (ps2_data_in),
        .level    (data_f)
    );

    assign clk_fall = clk_f_prev & ~clk_f;
    // Counters stick at all-ones instead of wrapping.
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);
    assign pkt_inc  = (pkt_q == '1) ? pkt_q : pkt_q + cnt_t'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pkt_d     = pkt_q;
        edge_d    = edge_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        ack_err_d = ack_err_q;
        err_d     = err_q;
        clk_pd_d  = clk_pd_q;
        data_pd_d = data_pd_q;
        n         = edge_q + 4'd1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_if.tx_valid) begin
                    byte_d    = tx_if.tx_data;
                    parity_d  = ~^tx_if.tx_data;
                    edge_d    = '0;
                    ack_err_d = 1'b0;
                    err_d     = PS2_OK;
                    clk_pd_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_d    = cnt_inc;
                clk_pd_d = 1'b1;
                // Start bit goes low on the final inhibit cycle, before the clock is released.
                if (cnt_q >= INH_DATA) data_pd_d = 1'b1;
                if (cnt_q >= INH_LAST) begin
                    clk_pd_d  = 1'b0;
                    data_pd_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = REQUEST;
                end
            end
            REQUEST: begin
                cnt_d = cnt_inc;
                if (clk_fall) begin
                    data_pd_d = ~byte_q[0];
                    pkt_d     = '0;
                    edge_d    = '0;
                    state_d   = SHIFT;
                end else if (cnt_q >= REQ_LAST) begin
                    data_pd_d = 1'b0;
                    err_d     = PS2_ERR_REQ;
                    state_d   = FINISH;
                end
            end
            SHIFT, ACK, WAIT_RELEASE: begin
                pkt_d = pkt_inc;
                if (pkt_q >= PKT_LAST) begin
                    clk_pd_d  = 1'b0;
                    data_pd_d = 1'b0;
                    err_d     = PS2_ERR_PKT;
                    state_d   = FINISH;
                end else begin
                    case (state_q)
                        SHIFT: begin
                            if (clk_fall) begin
                                edge_d = n;
                                if (n <= 4'd7)       data_pd_d = ~byte_q[n[2:0]];
                                else if (n == 4'd8)  data_pd_d = ~parity_q;
                                else if (n == 4'd9)  data_pd_d = 1'b0;
                                else begin
                                    // The device must already hold data low on this fall.
                                    ack_err_d = data_f;
                                    state_d   = ACK;
                                end
                            end
                        end
                        ACK: state_d = WAIT_RELEASE;
                        WAIT_RELEASE: begin
                            if (clk_f && data_f) begin
                                err_d   = ack_err_q ? PS2_ERR_ACK : PS2_OK;
                                state_d = FINISH;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            FINISH: begin
                clk_pd_d  = 1'b0;
                data_pd_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pkt_q      <= '0;
            edge_q     <= '0;
            byte_q     <= '0;
            parity_q   <= 1'b0;
            ack_err_q  <= 1'b0;
            err_q      <= PS2_OK;
            clk_pd_q   <= 1'b0;
            data_pd_q  <= 1'b0;
            clk_f_prev <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pkt_q      <= pkt_d;
            edge_q     <= edge_d;
            byte_q     <= byte_d;
            parity_q   <= parity_d;
            ack_err_q  <= ack_err_d;
            err_q      <= err_d;
            clk_pd_q   <= clk_pd_d;
            data_pd_q  <= data_pd_d;
            clk_f_prev <= clk_f;
        end
    end

    assign tx_if.tx_ready   = (state_q == IDLE);
    assign tx_if.busy       = (state_q != IDLE);
    assign tx_if.done_pulse = (state_q == FINISH);
    assign tx_if.error_code = err_q;
    assign rx_inhibit       = (state_q != IDLE);
    assign ps2_clock_pulldown = clk_pd_q;
    assign ps2_data_pulldown  = data_pd_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
module tb_ps2_host_transmitter;
    import ps2_pkg::*;

    localparam int INH  = 100;
    localparam int FILT = 2;
    localparam int REQ  = 3000;
    localparam int PKT  = 6000;
    localparam int HALF = 40;

    logic main_clk = 1'b0;
    logic reset    = 1'b1;
    always #5 main_clk = ~main_clk;

    ps2_host_transmitter_if tx_if();
    logic rx_inhibit, ps2_clock_pulldown, ps2_data_pulldown;
    logic ps2_clock_in, ps2_data_in;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    // Open-drain bus with pull-ups: either side pulling makes the line low.
    assign ps2_clock_in = ~(ps2_clock_pulldown | dev_clk_low);
    assign ps2_data_in  = ~(ps2_data_pulldown | dev_data_low);

    ps2_host_transmitter #(
        .INHIBIT_CYCLES     (INH),
        .FILTER_CYCLES      (FILT),
        .REQ_TIMEOUT_CYCLES (REQ),
        .PKT_TIMEOUT_CYCLES (PKT)
    ) dut (
        .main_clk           (main_clk),
        .reset              (reset),
        .tx_if              (tx_if),
        .rx_inhibit         (rx_inhibit),
        .ps2_clock_in       (ps2_clock_in),
        .ps2_data_in        (ps2_data_in),
        .ps2_clock_pulldown (ps2_clock_pulldown),
        .ps2_data_pulldown  (ps2_data_pulldown)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc_now = 0;
    int done_cnt = 0;
    int done_at = 0;
    logic [1:0] done_err = 2'd0;
    int acc_cnt = 0;
    int low_run = 0;
    int last_low = 0;
    int first_fall_at = 0;
    int ack_release_at = 0;

    always @(posedge main_clk) cyc_now <= cyc_now + 1;

    always @(negedge main_clk) begin
        if (tx_if.done_pulse === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_at  <= cyc_now;
            done_err <= tx_if.error_code;
        end
        if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1 && !reset) acc_cnt <= acc_cnt + 1;
        if (ps2_clock_pulldown === 1'b1) low_run <= low_run + 1;
        else if (low_run != 0) begin
            last_low <= low_run;
            low_run  <= 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Reference frame as the device sees it on rising edges: start, d[0..7], odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge main_clk);
        #1;
    endtask

    task automatic start_tx(input logic [7:0] d);
        int t = 0;
        while (tx_if.tx_ready !== 1'b1 && t < 100) begin cyc(1); t++; end
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        cyc(1);
        tx_if.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base, output bit seen);
        int t = 0;
        while (done_cnt == base && t < budget) begin cyc(1); t++; end
        seen = (done_cnt != base);
    endtask

    // Keyboard model: waits out the inhibit, samples start at clock release, then clocks n_edges pulses.
    task automatic device_xfer(input int n_edges, input int ack_hold, input bit do_ack,
                               output logic [10:0] smp, output bit ok);
        int t;
        ok = 1'b1;
        smp = '1;
        t = 0;
        while (ps2_clock_pulldown !== 1'b1 && t < 1000) begin cyc(1); t++; end
        if (t >= 1000) ok = 1'b0;
        t = 0;
        while (ps2_clock_pulldown !== 1'b0 && t < 1000) begin cyc(1); t++; end
        if (t >= 1000) ok = 1'b0;
        if (ok) begin
            smp[0] = ps2_data_in;
            cyc($urandom_range(60, 5));
            for (int k = 1; k <= n_edges; k++) begin
                if (k == 11 && do_ack) begin
                    dev_data_low = 1'b1;
                    cyc(20);
                end
                dev_clk_low = 1'b1;
                if (k == 1) first_fall_at = cyc_now;
                cyc((k == 11) ? ack_hold : HALF);
                dev_clk_low = 1'b0;
                if (k == 11) ack_release_at = cyc_now;
                if (k <= 10) smp[k] = ps2_data_in;
                cyc(HALF);
            end
            dev_data_low = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        reset = 1'b1;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        cyc(3);
        got = {tx_if.tx_ready, tx_if.busy, tx_if.done_pulse, rx_inhibit,
               ps2_clock_pulldown, ps2_data_pulldown, tx_if.error_code};
        n_cmp++;
        if (got !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_state: got %b required 10000000 (ready,busy,done,inh,cpd,dpd,err)", got);
        end
        reset = 1'b0;
        cyc(5);
    endtask

    task automatic test_frames();
        logic [7:0]  list[$];
        logic [10:0] smp;
        bit ok, seen;
        int base;
        list.push_back(8'hED);
        list.push_back(8'h01);
        list.push_back(8'hFF);
        repeat (4) list.push_back(8'($urandom_range(255, 0)));
        foreach (list[i]) begin
            base = done_cnt;
            start_tx(list[i]);
            n_cmp++;
            if ({tx_if.tx_ready, tx_if.busy, rx_inhibit} !== 3'b011) begin
                n_fail++;
                $display("FAIL accept_flags %02h: ready,busy,inh=%b required 011",
                         list[i], {tx_if.tx_ready, tx_if.busy, rx_inhibit});
            end
            device_xfer(11, HALF, 1'b1, smp, ok);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL device_sync %02h: bus never released", list[i]); end
            n_cmp++;
            if (smp !== frame_of(list[i])) begin
                n_fail++;
                $display("FAIL frame %02h: sampled %b required %b", list[i], smp, frame_of(list[i]));
            end
            n_cmp++;
            if (last_low != INH) begin
                n_fail++;
                $display("FAIL inhibit_len %02h: clock low %0d cycles required %0d", list[i], last_low, INH);
            end
            wait_done(200, base, seen);
            n_cmp++;
            if (!seen || done_err !== PS2_OK) begin
                n_fail++;
                $display("FAIL done_ok %02h: seen=%0d err=%0d required seen=1 err=0", list[i], seen, done_err);
            end
            cyc(3);
            n_cmp++;
            if (done_cnt != base + 1 || {ps2_clock_pulldown, ps2_data_pulldown} !== 2'b00) begin
                n_fail++;
                $display("FAIL done_once %02h: pulses %0d pds %b required 1 and 00",
                         list[i], done_cnt - base, {ps2_clock_pulldown, ps2_data_pulldown});
            end
        end
    endtask

    task automatic test_req_timeout();
        int t = 0;
        start_tx(8'hA5);
        while (ps2_clock_pulldown !== 1'b1 && t < 200) begin cyc(1); t++; end
        t = 0;
        while (ps2_clock_pulldown !== 1'b0 && t < 200) begin cyc(1); t++; end
        t = 0;
        while (tx_if.done_pulse !== 1'b1 && t < REQ + 200) begin cyc(1); t++; end
        n_cmp++;
        if (t < REQ - 1 || t > REQ + 1) begin
            n_fail++;
            $display("FAIL req_timeout_len: done after %0d cycles required %0d", t, REQ);
        end
        n_cmp++;
        if ({tx_if.error_code, ps2_clock_pulldown, ps2_data_pulldown} !== {PS2_ERR_REQ, 2'b00}) begin
            n_fail++;
            $display("FAIL req_timeout_state: err=%0d pds=%b required err=1 pds=00",
                     tx_if.error_code, {ps2_clock_pulldown, ps2_data_pulldown});
        end
        cyc(5);
    endtask

    task automatic test_no_ack();
        logic [10:0] smp;
        bit ok, seen;
        int base = done_cnt;
        start_tx(8'h96);
        device_xfer(11, 300, 1'b0, smp, ok);
        wait_done(200, base, seen);
        n_cmp++;
        if (!seen || done_err !== PS2_ERR_ACK) begin
            n_fail++;
            $display("FAIL no_ack_err: seen=%0d err=%0d required seen=1 err=3", seen, done_err);
        end
        n_cmp++;
        if (done_at <= ack_release_at || done_at > ack_release_at + 20) begin
            n_fail++;
            $display("FAIL no_ack_timing: done at %0d, clock released at %0d; done must follow release",
                     done_at, ack_release_at);
        end
        cyc(5);
    endtask

    task automatic test_pkt_timeout();
        logic [10:0] smp;
        bit ok;
        int t = 0;
        int delta;
        start_tx(8'h5A);
        device_xfer(4, HALF, 1'b0, smp, ok);
        while (tx_if.done_pulse !== 1'b1 && t < PKT + 500) begin cyc(1); t++; end
        delta = cyc_now - first_fall_at;
        n_cmp++;
        if (delta < PKT || delta > PKT + 10) begin
            n_fail++;
            $display("FAIL pkt_timeout_len: done %0d cycles after first fall, required %0d..%0d",
                     delta, PKT, PKT + 10);
        end
        n_cmp++;
        if ({tx_if.error_code, ps2_clock_pulldown, ps2_data_pulldown} !== {PS2_ERR_PKT, 2'b00}) begin
            n_fail++;
            $display("FAIL pkt_timeout_state: err=%0d pds=%b required err=2 pds=00",
                     tx_if.error_code, {ps2_clock_pulldown, ps2_data_pulldown});
        end
        cyc(5);
    endtask

    task automatic test_reset_mid();
        logic [10:0] smp;
        bit ok;
        int base;
        start_tx(8'h00);
        device_xfer(4, HALF, 1'b0, smp, ok);
        n_cmp++;
        if (ps2_data_pulldown !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_shift_data: data_pulldown=%b required 1 before reset", ps2_data_pulldown);
        end
        base = done_cnt;
        reset = 1'b1;
        cyc(1);
        n_cmp++;
        if ({ps2_clock_pulldown, ps2_data_pulldown, tx_if.tx_ready, tx_if.busy, rx_inhibit} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_mid: cpd,dpd,ready,busy,inh=%b required 00100",
                     {ps2_clock_pulldown, ps2_data_pulldown, tx_if.tx_ready, tx_if.busy, rx_inhibit});
        end
        reset = 1'b0;
        cyc(50);
        n_cmp++;
        if (done_cnt != base) begin
            n_fail++;
            $display("FAIL reset_mid_done: %0d done pulses required 0", done_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] smp;
        bit ok, seen;
        int base = done_cnt;
        int acc0 = acc_cnt;
        tx_if.tx_data  = 8'h3C;
        tx_if.tx_valid = 1'b1;
        device_xfer(11, HALF, 1'b1, smp, ok);
        wait_done(200, base, seen);
        n_cmp++;
        if (!seen || acc_cnt - acc0 != 1) begin
            n_fail++;
            $display("FAIL held_valid_single: seen=%0d accepts=%0d required 1 and 1", seen, acc_cnt - acc0);
        end
        n_cmp++;
        if (smp !== frame_of(8'h3C)) begin
            n_fail++;
            $display("FAIL held_valid_frame: sampled %b required %b", smp, frame_of(8'h3C));
        end
        cyc(2);
        tx_if.tx_valid = 1'b0;
        n_cmp++;
        if (acc_cnt - acc0 != 2 || tx_if.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_valid_restart: accepts=%0d busy=%b required 2 and 1", acc_cnt - acc0, tx_if.busy);
        end
        base = done_cnt;
        device_xfer(11, HALF, 1'b1, smp, ok);
        wait_done(200, base, seen);
        n_cmp++;
        if (!seen || done_err !== PS2_OK || smp !== frame_of(8'h3C)) begin
            n_fail++;
            $display("FAIL second_xfer: seen=%0d err=%0d frame %b required 1, 0, %b",
                     seen, done_err, smp, frame_of(8'h3C));
        end
        cyc(5);
    endtask

    initial begin
        test_reset();
        test_frames();
        test_req_timeout();
        test_no_ack();
        test_pkt_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
